// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Arbiter and boot sequencer for the single-port instruction
//                memory. Shares the memory between the fetch path (PC
//                driven, read-only) and the program loader (read/write).
//                After reset the loader owns the memory and the PC is held
//                stalled until the loader signals completion (ld_done).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            rising-edge clock
//    reset          asynchronous, active-low reset
//    fetch_*        fetch requester: req/addr in, gnt/rvalid/rdata out
//    pc_stall       hold the program counter this cycle
//    ld_*           loader requester: req/we/addr/wdata in, gnt/rvalid/rdata out
//    ld_done        one-cycle pulse, loading complete (BOOT -> RUN)
//    reboot         one-cycle pulse, return to BOOT (wins over ld_done)
//    mem_*          single-port memory interface (rdata valid one cycle after
//                   a read access)
//    boot_active    FSM is in BOOT
//  Configuration
//    IMEM_ARB_STARVE_GUARD_EN  when defined, fetch is granted once after
//                              MAX_BURST consecutive loader wins against a
//                              waiting fetch. Undefined: strict loader priority.
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              pc_stall,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_done,
    input  logic              reboot,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              boot_active
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Read-ownership flags: who gets mem_rdata in the cycle after a read.
    logic fetch_own_q;
    logic fetch_own_d;
    logic ld_own_q;
    logic ld_own_d;

    // Starvation override: fetch takes this cycle despite a loader request.
    logic w_fetch_wins;

    // ------------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------------
`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign w_fetch_wins = (state_q == ST_RUN) && ld_req && fetch_req &&
                          (starve_cnt_q == CNT_W'(MAX_BURST));

    // Counts loader wins against a waiting fetch. Any cycle in which fetch
    // is not waiting (no request, or granted) restarts the burst count.
    // BOOT never counts, so each RUN period starts with a fresh budget.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((state_q != ST_RUN) || !fetch_req || fetch_gnt) begin
            starve_cnt_d = '0;
        end else if (ld_gnt) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign w_fetch_wins = 1'b0;

    // MAX_BURST only matters when the guard is built in.
    logic w_unused_max_burst;
    assign w_unused_max_burst = ^MAX_BURST;
`endif

    // ------------------------------------------------------------------------
    // FSM: next state and grants
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Loader owns the memory exclusively; an access granted in
                // the ld_done cycle completes normally.
                ld_gnt = ld_req;
                if (!reboot && ld_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                ld_gnt    = ld_req & ~w_fetch_wins;
                fetch_gnt = fetch_req & ~ld_gnt;
                // ld_done is meaningless here and is ignored.
                if (reboot) begin
                    state_d = ST_BOOT;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    assign boot_active = (state_q == ST_BOOT);
    assign pc_stall    = boot_active | (fetch_req & ~fetch_gnt);

    // ------------------------------------------------------------------------
    // Memory request mux
    // ------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (fetch_gnt) begin
            mem_addr  = fetch_addr;
        end
    end

    assign mem_en = fetch_gnt | ld_gnt;

    // ------------------------------------------------------------------------
    // Read return routing (1-cycle latency)
    // ------------------------------------------------------------------------
    assign fetch_own_d = fetch_gnt;
    assign ld_own_d    = ld_gnt & ~ld_we;

    // Async clear guarantees a read in flight at reset never reports valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_own_q <= 1'b0;
            ld_own_q    <= 1'b0;
        end else begin
            fetch_own_q <= fetch_own_d;
            ld_own_q    <= ld_own_d;
        end
    end

    assign fetch_rvalid = fetch_own_q;
    assign ld_rvalid    = ld_own_q;
    assign fetch_rdata  = fetch_own_q ? mem_rdata : '0;
    assign ld_rdata     = ld_own_q    ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Self-checking bench for imem_arbiter. A behavioural memory
//                answers the DUT's memory port; expected read data comes from
//                a shadow copy updated from the stimulus. Grants and memory
//                outputs are checked in the request cycle, read returns are
//                popped from per-requester queues one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic              clk;
    logic              reset;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              pc_stall;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_done;
    logic              reboot;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              boot_active;

    imem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_rvalid(fetch_rvalid),
        .fetch_rdata (fetch_rdata),
        .pc_stall    (pc_stall),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .ld_done     (ld_done),
        .reboot      (reboot),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .boot_active (boot_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory driven by the DUT.
    logic [DATA_W-1:0] tbmem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tbmem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= tbmem[mem_addr[3:0]];
        end
    end

    logic [DATA_W-1:0] shadow [16];
    logic [DATA_W-1:0] exp_f [$];
    logic [DATA_W-1:0] exp_l [$];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        lr;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        efg;
        logic        elg;
        logic        est;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs and any
    // read return due this cycle, then record the reads this cycle launches.
    task automatic cyc(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd,
                       input logic dn, input logic rb,
                       input logic efg, input logic elg, input logic est,
                       input logic ebt);
        logic [DATA_W-1:0] d;
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        ld_req     = lr;
        ld_we      = lwe;
        ld_addr    = la;
        ld_wdata   = lwd;
        ld_done    = dn;
        reboot     = rb;
        #2;
        chk("boot_active", {31'd0, boot_active}, {31'd0, ebt});
        chk("fetch_gnt",   {31'd0, fetch_gnt},   {31'd0, efg});
        chk("ld_gnt",      {31'd0, ld_gnt},      {31'd0, elg});
        chk("pc_stall",    {31'd0, pc_stall},    {31'd0, est});
        chk("mem_en",      {31'd0, mem_en},      {31'd0, efg | elg});
        if (elg) begin
            chk("mem_we(ld)",  {31'd0, mem_we}, {31'd0, lwe});
            chk("mem_addr(ld)", mem_addr, la);
            if (lwe) chk("mem_wdata", mem_wdata, lwd);
        end else if (efg) begin
            chk("mem_we(fetch)", {31'd0, mem_we}, 32'd0);
            chk("mem_addr(fetch)", mem_addr, fa);
        end
        if (exp_f.size() > 0) begin
            d = exp_f.pop_front();
            chk("fetch_rvalid", {31'd0, fetch_rvalid}, 32'd1);
            chk("fetch_rdata", fetch_rdata, d);
        end else begin
            chk("fetch_rvalid", {31'd0, fetch_rvalid}, 32'd0);
            chk("fetch_rdata(idle)", fetch_rdata, 32'd0);
        end
        if (exp_l.size() > 0) begin
            d = exp_l.pop_front();
            chk("ld_rvalid", {31'd0, ld_rvalid}, 32'd1);
            chk("ld_rdata", ld_rdata, d);
        end else begin
            chk("ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
            chk("ld_rdata(idle)", ld_rdata, 32'd0);
        end
        if (efg)         exp_f.push_back(shadow[fa[3:0]]);
        if (elg && !lwe) exp_l.push_back(shadow[la[3:0]]);
        if (elg && lwe)  shadow[la[3:0]] = lwd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        vecs[0] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 32'h0,         1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 32'hCAFEF00D,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'd0, 1'b1, 1'b0, 32'd3, 32'h0,         1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'd2, 1'b1, 1'b1, 32'd4, 32'h0BADC0DE,  1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 32'd4, 1'b0, 1'b0, 32'd0, 32'h0,         1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'd3, 1'b1, 1'b0, 32'd4, 32'h0,         1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0,         1'b0, 1'b0, 1'b0};

        reset = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        ld_done = 1'b0; reboot = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst boot_active", {31'd0, boot_active}, 32'd1);
        chk("rst pc_stall",    {31'd0, pc_stall},    32'd1);
        chk("rst gnts",        {30'd0, fetch_gnt, ld_gnt}, 32'd0);
        chk("rst rvalids",     {30'd0, fetch_rvalid, ld_rvalid}, 32'd0);
        chk("rst mem_en",      {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // BOOT: fetch is ignored, loader writes the program
        cyc(1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 1, 0, 32'h20080005, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1);
        // ld_done held two cycles: one transition only; same-cycle write lands
        cyc(0, 0, 1, 1, 2, 32'h12345678, 1, 0, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0,            1, 0, 1, 0, 0, 0);
        // back-to-back fetch reads
        cyc(1, 1, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0,            0, 0, 0, 1, 0, 0);

        // Table-driven RUN arbitration
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].fr, vecs[i].fa, vecs[i].lr, vecs[i].lwe, vecs[i].la,
                vecs[i].lwd, 0, 0, vecs[i].efg, vecs[i].elg, vecs[i].est, 0);
        end

        // Contention: both request for 10 cycles
        for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
            g = ((i % 5) == 4);
`else
            g = 1'b0;
`endif
            cyc(1, 0, 1, 0, 1, 0, 0, 0, g, ~g, ~g, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reboot held two cycles: back to BOOT, fetch locked out
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        // Loader read granted, then reset before the return
        cyc(0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 1, 1);
        #1;
        reset = 1'b0;
        ld_req = 1'b0; fetch_req = 1'b0;
        exp_l.delete();
        exp_f.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst-mid ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
            chk("rst-mid boot_active", {31'd0, boot_active}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
